// File: rtl/bin_to_bcd_pkg.sv
// bin_to_bcd_pkg: shared state encoding and add-3 constants for the BCD converter.
// Rev 1.0
`default_nettype none

package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL    = 4'd3;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble nibble correction, adds 3 when the digit is 5 or more.
// Rev 1.0
`default_nettype none

module bcd_digit_adj
  import bin_to_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= ADD3_THRESH) ? digit + ADD3_VAL : digit;

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BIN2BCD_OVF_EN to add the sticky overflow output ovf. Rev 1.0
`default_nettype none

module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  C,
  input  logic                  Cl,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
`ifdef BIN2BCD_OVF_EN
  output logic                  ovf,
`endif
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  state_t             state;
  state_t             state_nxt;
  logic [BCD_W-1:0]   bcd_work;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;
  logic [IN_W-1:0]    bin_work;
  logic [CNT_W-1:0]   bit_cnt;
  logic               last_shift;
  logic               accept;

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_digit_adj u_adj (
        .digit    (bcd_work[4*k +: 4]),
        .adjusted (bcd_adj[4*k +: 4])
      );
    end
  endgenerate

  // The top bit of bcd_adj falls off here; that is the truncation to DIGITS digits.
  assign bcd_shift  = (bcd_adj << 1) | BCD_W'(bin_work[IN_W-1]);
  assign last_shift = (bit_cnt == CNT_W'(IN_W - 1));
  assign accept     = start & ~busy;

  always_ff @(posedge C or negedge Cl) begin
    if (!Cl) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_SHIFT: begin
        busy      = 1'b1;
        state_nxt = last_shift ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = start ? ST_SHIFT : ST_IDLE;
      end
    endcase
  end

  // bcd is loaded on the edge that enters DONE so it is already valid while done is high.
  always_ff @(posedge C or negedge Cl) begin
    if (!Cl) begin
      bcd_work <= '0;
      bin_work <= '0;
      bit_cnt  <= '0;
      bcd      <= '0;
    end else if (accept) begin
      bcd_work <= '0;
      bin_work <= bin;
      bit_cnt  <= '0;
    end else if (state == ST_SHIFT) begin
      bcd_work <= bcd_shift;
      bin_work <= bin_work << 1;
      bit_cnt  <= bit_cnt + CNT_W'(1);
      if (last_shift) begin
        bcd <= bcd_shift;
      end
    end
  end

`ifdef BIN2BCD_OVF_EN
  logic ovf_flag;
  logic ovf_flag_nxt;

  assign ovf_flag_nxt = ovf_flag | bcd_adj[BCD_W-1];

  always_ff @(posedge C or negedge Cl) begin
    if (!Cl) begin
      ovf_flag <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      ovf_flag <= 1'b0;
    end else if (state == ST_SHIFT) begin
      ovf_flag <= ovf_flag_nxt;
      if (last_shift) begin
        ovf <= ovf_flag_nxt;
      end
    end
  end
`endif

endmodule

`default_nettype wire
